// File: rtl/async_bus_master.sv
// Initiator for the strobe bus: turns one valid/ready command into a timed
// setup/strobe/hold/recovery cycle and returns a one-cycle response.
module async_bus_master #(
    parameter int SETUP_CYCLES    = 2,
    parameter int STROBE_CYCLES   = 8,
    parameter int HOLD_CYCLES     = 2,
    parameter int RECOVERY_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_write,
    input  logic [23:0] cmd_addr,
    input  logic [31:0] cmd_wdata,
    input  logic [3:0]  cmd_be,
    output logic        rsp_valid,
    output logic        rsp_write,
    output logic [31:0] rsp_rdata,
    output logic        busy,
    output logic [23:0] address,
    output logic [31:0] data_out,
    input  logic [31:0] data_in,
    output logic [3:0]  be,
    output logic        ws_n,
    output logic        rs_n,
    output logic        as
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        SETUP   = 3'd1,
        STROBE  = 3'd2,
        HOLD    = 3'd3,
        RECOVER = 3'd4
    } state_t;

    // Each phase loads its length minus one so that a count of zero marks its last cycle.
    localparam logic [7:0] SETUP_LOAD    = 8'(SETUP_CYCLES - 1);
    localparam logic [7:0] STROBE_LOAD   = 8'(STROBE_CYCLES - 1);
    localparam logic [7:0] HOLD_LOAD     = 8'(HOLD_CYCLES - 1);
    localparam logic [7:0] RECOVERY_LOAD = 8'(RECOVERY_CYCLES - 1);

    state_t      state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic        write_q, write_d;
    logic [23:0] address_q, address_d;
    logic [31:0] data_out_q, data_out_d;
    logic [3:0]  be_q, be_d;
    logic        ws_n_q, ws_n_d;
    logic        rs_n_q, rs_n_d;
    logic        as_q, as_d;
    logic        rsp_valid_q, rsp_valid_d;
    logic        rsp_write_q, rsp_write_d;
    logic [31:0] rsp_rdata_q, rsp_rdata_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= 8'd0;
            write_q     <= 1'b0;
            address_q   <= 24'd0;
            data_out_q  <= 32'd0;
            be_q        <= 4'd0;
            ws_n_q      <= 1'b1;
            rs_n_q      <= 1'b1;
            as_q        <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_write_q <= 1'b0;
            rsp_rdata_q <= 32'd0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            write_q     <= write_d;
            address_q   <= address_d;
            data_out_q  <= data_out_d;
            be_q        <= be_d;
            ws_n_q      <= ws_n_d;
            rs_n_q      <= rs_n_d;
            as_q        <= as_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_write_q <= rsp_write_d;
            rsp_rdata_q <= rsp_rdata_d;
        end
    end

    // Outputs are computed one cycle ahead so every bus pin comes straight from a flop.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        write_d     = write_q;
        address_d   = address_q;
        data_out_d  = data_out_q;
        be_d        = be_q;
        ws_n_d      = ws_n_q;
        rs_n_d      = rs_n_q;
        as_d        = as_q;
        rsp_valid_d = 1'b0;
        rsp_write_d = rsp_write_q;
        rsp_rdata_d = rsp_rdata_q;

        case (state_q)
            IDLE: begin
                if (cmd_valid) begin
                    state_d    = SETUP;
                    cnt_d      = SETUP_LOAD;
                    write_d    = cmd_write;
                    address_d  = cmd_addr;
                    be_d       = cmd_be;
                    data_out_d = cmd_write ? cmd_wdata : 32'd0;
                    as_d       = 1'b1;
                end
            end
            SETUP: begin
                if (cnt_q == 8'd0) begin
                    state_d = STROBE;
                    cnt_d   = STROBE_LOAD;
                    ws_n_d  = ~write_q;
                    rs_n_d  = write_q;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            STROBE: begin
                if (cnt_q == 8'd0) begin
                    state_d = HOLD;
                    cnt_d   = HOLD_LOAD;
                    ws_n_d  = 1'b1;
                    rs_n_d  = 1'b1;
                    if (!write_q) begin
                        rsp_rdata_d = data_in;
                    end
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            HOLD: begin
                if (cnt_q == 8'd0) begin
                    state_d     = RECOVER;
                    cnt_d       = RECOVERY_LOAD;
                    as_d        = 1'b0;
                    rsp_valid_d = 1'b1;
                    rsp_write_d = write_q;
                    if (write_q) begin
                        rsp_rdata_d = 32'd0;
                    end
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            RECOVER: begin
                if (cnt_q == 8'd0) begin
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            default: begin
                state_d = IDLE;
                ws_n_d  = 1'b1;
                rs_n_d  = 1'b1;
                as_d    = 1'b0;
            end
        endcase
    end

    assign cmd_ready = (state_q == IDLE);
    assign busy      = (state_q != IDLE);
    assign rsp_valid = rsp_valid_q;
    assign rsp_write = rsp_write_q;
    assign rsp_rdata = rsp_rdata_q;
    assign address   = address_q;
    assign data_out  = data_out_q;
    assign be        = be_q;
    assign ws_n      = ws_n_q;
    assign rs_n      = rs_n_q;
    assign as        = as_q;

endmodule
